// File: rtl/mem_access_unit.sv
// Byte/halfword load-store sequencer for an 8-bit data-memory port.
// Each request becomes one or two single-byte RAM cycles followed by a one-cycle response pulse.
module mem_access_unit #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned BYTE_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic                req_half_i,
    input  logic                req_signed_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [2*BYTE_W-1:0] req_wdata_i,
    output logic                rsp_valid_o,
    output logic [2*BYTE_W-1:0] rsp_rdata_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [BYTE_W-1:0]   mem_din_o,
    input  logic [BYTE_W-1:0]   mem_dout_i
);

    localparam int unsigned HALF_W = 2 * BYTE_W;

    typedef enum logic [1:0] {StIdle, StLo, StHi, StResp} state_e;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic                half_q, half_d;
    logic                signed_q, signed_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [HALF_W-1:0]   wdata_q, wdata_d;
    logic [BYTE_W-1:0]   lo_q, lo_d;
    logic [HALF_W-1:0]   rsp_q, rsp_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            half_q   <= 1'b0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            lo_q     <= '0;
            rsp_q    <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            half_q   <= half_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            lo_q     <= lo_d;
            rsp_q    <= rsp_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        half_d   = half_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        lo_d     = lo_q;
        rsp_d    = rsp_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    we_d     = req_we_i;
                    half_d   = req_half_i;
                    signed_d = req_signed_i;
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                    state_d  = StLo;
                end
            end
            StLo: begin
                if (half_q) begin
                    // Low byte is parked until the high byte arrives so the response updates once.
                    lo_d    = mem_dout_i;
                    state_d = StHi;
                end else begin
                    rsp_d   = we_q ? '0
                                   : {{BYTE_W{signed_q & mem_dout_i[BYTE_W-1]}}, mem_dout_i};
                    state_d = StResp;
                end
            end
            StHi: begin
                rsp_d   = we_q ? '0 : {mem_dout_i, lo_q};
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // RAM-side outputs depend only on registered state, never on the request inputs.
    always_comb begin
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_din_o  = '0;
        case (state_q)
            StLo: begin
                mem_we_o   = we_q;
                mem_addr_o = addr_q;
                mem_din_o  = wdata_q[BYTE_W-1:0];
            end
            StHi: begin
                mem_we_o   = we_q;
                mem_addr_o = addr_q + ADDR_W'(1);
                mem_din_o  = wdata_q[HALF_W-1:BYTE_W];
            end
            default: begin
                mem_we_o   = 1'b0;
                mem_addr_o = '0;
                mem_din_o  = '0;
            end
        endcase
    end

    assign req_ready_o = (state_q == StIdle);
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_rdata_o = rsp_q;

endmodule
